// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared constants and types for the BTB/bimodal predictor
package branch_predictor_pkg;
  localparam int INDEX_BITS_DEF = 6;
  localparam int TAG_BITS_DEF = 8;
  localparam logic [1:0] CTR_INIT = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  typedef logic [INDEX_BITS_DEF-1:0] br_index_t;
endpackage

// File: rtl/branch_predictor_sat_ctr2.sv
// sat_ctr2: combinational 2-bit saturating increment/decrement
module sat_ctr2 (
  input  logic       inc,
  input  logic [1:0] ctr,
  output logic [1:0] ctr_nxt
);
  always_comb ctr_nxt = inc ? ((ctr == 2'b11) ? ctr : ctr + 2'd1)
                            : ((ctr == 2'b00) ? ctr : ctr - 2'd1);
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: branch target buffer with 2-bit bimodal counters, lookup at IF, update from EX
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int TAG_BITS = TAG_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           if_pc,
  output logic [INDEX_BITS-1:0] if_br_index,
  output logic                  if_prd_jmp,
  output logic [31:0]           if_prd_target,
  input  logic                  ex_upd,
  input  logic [INDEX_BITS-1:0] ex_br_index,
  input  logic [31:0]           ex_pc,
  input  logic                  ex_prd_jmp,
  input  logic [31:0]           ex_prd_target,
  input  logic                  ex_taken,
  input  logic [31:0]           ex_target,
  output logic                  ex_mispredict
);
  localparam int DEPTH = 1 << INDEX_BITS;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q [DEPTH];
  logic [TAG_BITS-1:0] tag_d [DEPTH];
  logic [31:0]         target_q [DEPTH];
  logic [31:0]         target_d [DEPTH];
  logic [1:0]          ctr_q [DEPTH];
  logic [1:0]          ctr_d [DEPTH];
  logic [TAG_BITS-1:0] if_tag, ex_tag;
  logic                ex_hit;
  logic [1:0]          ctr_nxt;
  logic                unused_pc_bits;

  assign if_tag = if_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign ex_tag = ex_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign unused_pc_bits = ^{if_pc[31:INDEX_BITS+TAG_BITS+2], if_pc[1:0],
                            ex_pc[31:INDEX_BITS+TAG_BITS+2], ex_pc[INDEX_BITS+1:0]};

  assign if_br_index   = if_pc[INDEX_BITS+1:2];
  assign if_prd_jmp    = valid_q[if_br_index] && (tag_q[if_br_index] == if_tag) && ctr_q[if_br_index][1];
  assign if_prd_target = if_prd_jmp ? target_q[if_br_index] : ZERO_WORD;

  assign ex_hit        = valid_q[ex_br_index] && (tag_q[ex_br_index] == ex_tag);
  assign ex_mispredict = ex_upd & ((ex_prd_jmp != ex_taken) | (ex_taken & (ex_prd_target != ex_target)));

  sat_ctr2 u_sat_ctr2 (
    .inc     (ex_taken),
    .ctr     (ctr_q[ex_br_index]),
    .ctr_nxt (ctr_nxt)
  );

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (ex_upd && ex_taken) begin
      valid_d[ex_br_index]  = 1'b1;
      tag_d[ex_br_index]    = ex_tag;
      target_d[ex_br_index] = ex_target;
      ctr_d[ex_br_index]    = ex_hit ? ctr_nxt : CTR_ALLOC;
    end else if (ex_upd && ex_hit) begin
      ctr_d[ex_br_index] = ctr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= ZERO_WORD;
        ctr_q[i]    <= CTR_INIT;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed-vector check of lookup, allocation, counters, aliasing and reset
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic [5:0]  if_br_index;
  logic        if_prd_jmp;
  logic [31:0] if_prd_target;
  logic        ex_upd;
  logic [5:0]  ex_br_index;
  logic [31:0] ex_pc;
  logic        ex_prd_jmp;
  logic [31:0] ex_prd_target;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_mispredict;
  int          n_vec = 0;
  int          n_miss = 0;

  branch_predictor dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_br_index(if_br_index),
    .if_prd_jmp(if_prd_jmp), .if_prd_target(if_prd_target), .ex_upd(ex_upd),
    .ex_br_index(ex_br_index), .ex_pc(ex_pc), .ex_prd_jmp(ex_prd_jmp),
    .ex_prd_target(ex_prd_target), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_mispredict(ex_mispredict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic jmp, input logic [31:0] tgt);
    if_pc = pc;
    #1;
    chk({tag, ".jmp"}, {31'b0, if_prd_jmp}, {31'b0, jmp});
    chk({tag, ".tgt"}, if_prd_target, tgt);
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                         input logic pj, input logic [31:0] pt);
    ex_upd = 1'b1;
    ex_pc = pc;
    ex_br_index = pc[7:2];
    ex_taken = taken;
    ex_target = tgt;
    ex_prd_jmp = pj;
    ex_prd_target = pt;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    ex_upd = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    set_upd(pc, taken, tgt, 1'b0, 32'h0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    if_pc = 32'h0;
    ex_upd = 1'b0;
    ex_br_index = '0;
    ex_pc = 32'h0;
    ex_prd_jmp = 1'b0;
    ex_prd_target = 32'h0;
    ex_taken = 1'b0;
    ex_target = 32'h0;
    tick();
    look("in_reset", 32'h40, 1'b0, 32'h0);
    rst = 1'b0;
    for (int a = 0; a <= 32'hFC; a += 4) look("sweep", a, 1'b0, 32'h0);
    // allocation in the same cycle as a lookup of that entry: no bypass
    set_upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    look("alloc_same_cycle", 32'h40, 1'b0, 32'h0);
    chk("alloc_mispredict", {31'b0, ex_mispredict}, 32'd1);
    tick();
    look("alloc_next", 32'h40, 1'b1, 32'h100);
    chk("index_0x40", {26'b0, if_br_index}, 32'd16);
    ex_prd_jmp = 1'b1;
    ex_taken = 1'b0;
    ex_target = 32'h999;
    #1;
    chk("no_upd_no_mispredict", {31'b0, ex_mispredict}, 32'd0);
    set_upd(32'h4040, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("alias_nt_mispredict", {31'b0, ex_mispredict}, 32'd0);
    tick();
    look("alias_nt_0x40", 32'h40, 1'b1, 32'h100);
    look("alias_0x4040_miss", 32'h4040, 1'b0, 32'h0);
    upd(32'h40, 1'b0, 32'h0);
    look("nt1_ctr01", 32'h40, 1'b0, 32'h0);
    upd(32'h40, 1'b0, 32'h0);
    look("nt2_ctr00", 32'h40, 1'b0, 32'h0);
    upd(32'h40, 1'b0, 32'h0);
    look("nt3_sat00", 32'h40, 1'b0, 32'h0);
    upd(32'h40, 1'b1, 32'h100);
    look("t_ctr01", 32'h40, 1'b0, 32'h0);
    upd(32'h40, 1'b1, 32'h100);
    look("t_ctr10", 32'h40, 1'b1, 32'h100);
    set_upd(32'h40, 1'b1, 32'h200, 1'b1, 32'h100);
    #1;
    chk("target_mispredict", {31'b0, ex_mispredict}, 32'd1);
    tick();
    look("t_ctr11_tgt", 32'h40, 1'b1, 32'h200);
    set_upd(32'h40, 1'b1, 32'h200, 1'b1, 32'h200);
    #1;
    chk("correct_pred", {31'b0, ex_mispredict}, 32'd0);
    tick();
    look("t_sat11", 32'h40, 1'b1, 32'h200);
    upd(32'h40, 1'b0, 32'h0);
    look("nt_ctr10", 32'h40, 1'b1, 32'h200);
    upd(32'h40, 1'b0, 32'h0);
    look("nt_ctr01", 32'h40, 1'b0, 32'h0);
    // taken miss on an aliasing PC replaces the entry
    upd(32'h4040, 1'b1, 32'h300);
    look("replace_new", 32'h4040, 1'b1, 32'h300);
    look("replace_old", 32'h40, 1'b0, 32'h0);
    rst = 1'b1;
    set_upd(32'h80, 1'b1, 32'h500, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    look("rst_drops_upd", 32'h80, 1'b0, 32'h0);
    look("rst_clears", 32'h4040, 1'b0, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Branch target buffer plus 2-bit bimodal history table for the five-stage RISC-V core. It produces the `id_br_index`/`id_prd_jmp` prediction that travels down the pipeline through IF/ID and ID/EX, and the predicted target used by the PC generator. The same prediction returns from EX as a resolution update, closing the loop. The lookup port sits beside the IF stage; the update port is driven by EX branch/jump resolution.

## Interface
- INDEX_BITS, 6, table depth 2^INDEX_BITS; index = pc[INDEX_BITS+1:2]; `BrIndexBus` is [INDEX_BITS-1:0]
- TAG_BITS, 8, tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]

Ports:
- clk  in  1  core clock
- rst  in  1  reset; one clock, reset synchronous and active-high (`True`)
- if_pc  in  32  fetch PC to look up
- if_br_index  out  INDEX_BITS  index of if_pc; carried down the pipeline
- if_prd_jmp  out  1  predicted taken
- if_prd_target  out  32  predicted target; ZeroWord when if_prd_jmp=0
- ex_upd  in  1  one-cycle pulse: a branch/jal/jalr resolved in EX
- ex_br_index  in  INDEX_BITS  index captured at fetch
- ex_pc  in  32  PC of resolving instruction
- ex_prd_jmp  in  1  prediction captured at fetch
- ex_prd_target  in  32  target predicted at fetch
- ex_taken  in  1  actual outcome
- ex_target  in  32  actual target
- ex_mispredict  out  1  combinational; ex_upd & ((ex_prd_jmp≠ex_taken) | (ex_taken & ex_prd_target≠ex_target))

## Operation
- Per entry: valid (1), tag (TAG_BITS), target (32), ctr (2-bit saturating).
- Lookup (combinational from registered table state): hit = valid[idx] & tag[idx]==tag(if_pc); if_prd_jmp = hit & ctr[idx][1]; if_prd_target = if_prd_jmp ? target[idx] : ZeroWord.
- Update on ex_upd, written at the rising edge, at entry ex_br_index; hit recomputed with tag(ex_pc):
  - taken & hit: ctr += 1 (saturate at 2'b11); target := ex_target.
  - taken & miss: allocate. Set valid=1, tag=tag(ex_pc), target=ex_target, ctr=2'b10. Any existing entry is replaced.
  - not taken & hit: ctr -= 1 (saturate at 2'b00); target unchanged.
  - not taken & miss: no change.
- The update ignores pipeline stall and clear. The EX driver guarantees exactly one ex_upd pulse per resolved instruction and none for flushed bubbles; ID/EX clear yields aluop NOP, so ex_upd=0.
- ex_mispredict is informational for the redirect/flush controller and is not registered here.

## Timing
- Reset (rst=1 at an edge): all valid:=0, ctr:=2'b01, tag:=0, target:=ZeroWord. During and after reset, if_prd_jmp=0 and if_prd_target=ZeroWord for every if_pc.
- Lookup latency 0: outputs follow if_pc in the same cycle.
- Update latency 1: a lookup in cycle N+1 sees an update applied at the end of cycle N.
- Same-index lookup and update in one cycle: the lookup returns pre-update contents, with no bypass.
- Reset asserted together with ex_upd: reset wins and the update is dropped.
- Aliasing: entries with the same index but a different tag never hit and never update ctr on not-taken.
- ex_mispredict is 0 whenever ex_upd=0.

## Structure
- Add `BrIndexBus`, `CtrInit` (2'b01) and `CtrAlloc` (2'b10) to defines.v.
- One natural sub-module, `sat_ctr2`: a combinational 2-bit saturating inc/dec, instantiated once on the update path.
- Table storage is flop arrays, not inferred RAM, because reset must clear valid.

## Test plan
- Reset, then sweep if_pc over 0x0000–0x00FC → if_prd_jmp=0 and if_prd_target=0 for all.
- ex_upd with ex_pc=0x40, taken, target=0x100 → next cycle if_pc=0x40 gives if_br_index=16, if_prd_jmp=1, if_prd_target=0x100.
- Same entry: three not-taken updates → ctr 10→01→00→00; prediction drops to 0 after the first and stays 0.
- Alias: entry for 0x40 valid, then a not-taken update from ex_pc=0x4040 (same index, tag differs) → entry unchanged, 0x40 still predicts taken.
- Lookup 0x40 in the same cycle as its allocating update → that cycle returns prd_jmp=0; the next cycle returns 1.
- Taken update with ex_prd_jmp=1, ex_prd_target=0x100, ex_target=0x200 → ex_mispredict=1, target updated to 0x200. Reset asserted with ex_upd → table stays cleared.
